i2s_pcm_mclk: RTL and testbench

- I2S receiver. Consumes the BCLK/LRCK/DATA stream produced by the I2S transmitter stage (PCM_I2S_MCLK) and deserializes it back into parallel signed left/right PCM words.
- Runs entirely on the master clock and oversamples the serial inputs, which are treated as asynchronous to it.
- Used as the downstream loopback and check stage, and as the front end for external I2S sources.

---
 rtl/i2s_pcm_mclk_if.sv | 23 ++
 rtl/i2s_pcm_mclk.sv | 182 ++++++++++++++++++
 tb/tb_i2s_pcm_mclk.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pcm_mclk_if.sv
// I2S receiver bus: serial inputs from the transmitter side and the
// parallel PCM frame outputs of the deserializer.
interface i2s_pcm_mclk_if #(
   parameter int DATA_WIDTH = 32
);
   logic                         BCLK_I;
   logic                         LRCK_I;
   logic                         DATA_I;
   logic signed [DATA_WIDTH-1:0] PCML_O;
   logic signed [DATA_WIDTH-1:0] PCMR_O;
   logic                         VALID_O;
   logic                         SLOT_ERR_O;

   modport master (
      output BCLK_I, LRCK_I, DATA_I,
      input  PCML_O, PCMR_O, VALID_O, SLOT_ERR_O
   );

   modport slave (
      input  BCLK_I, LRCK_I, DATA_I,
      output PCML_O, PCMR_O, VALID_O, SLOT_ERR_O
   );
endinterface

// File: rtl/i2s_pcm_mclk.sv
// I2S receiver: oversamples BCLK/LRCK/DATA on MCLK and rebuilds
// signed left/right PCM words, flagging slots shorter than the word.
module i2s_pcm_mclk #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 6
) (
   input logic           MCLK_I,
   input logic           ARESETN_I,
   i2s_pcm_mclk_if.slave i2s
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_L,
      S_HAVE_L
   } state_t;

   localparam logic [CNT_WIDTH-1:0] SHORT_LIM = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   bclk_s;
   logic                   lrck_s;
   logic                   data_s;
   logic                   bclk_d;
   logic                   rise;
   logic                   rise_q;
   logic                   lrck_q;
   logic                   data_q;
   logic                   lrck_last;
   logic [CNT_WIDTH-1:0]   bit_cnt;
   logic [DATA_WIDTH-1:0]  sh;
   logic [DATA_WIDTH-1:0]  word_in;
   logic [DATA_WIDTH-1:0]  left_hold;
   logic [DATA_WIDTH-1:0]  right_hold;
   logic                   lerr;
   logic                   rerr;
   logic                   slot_end;
   logic                   slot_short;
   logic                   left_load;
   logic                   frame_go;
   logic                   frame_q;
   state_t                 state;
   state_t                 state_nx;

   assign bclk_s = bclk_sync[SYNC_STAGES-1];
   assign lrck_s = lrck_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign rise   = bclk_s & ~bclk_d;

   // bring the asynchronous serial lines into the MCLK domain
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         data_sync <= '0;
         bclk_d    <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s.BCLK_I};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s.LRCK_I};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i2s.DATA_I};
         bclk_d    <= bclk_s;
      end
   end

   // register each BCLK rise together with the LRCK/DATA seen at it
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) begin
         rise_q <= 1'b0;
         lrck_q <= 1'b0;
         data_q <= 1'b0;
      end else begin
         rise_q <= rise;
         if (rise) begin
            lrck_q <= lrck_s;
            data_q <= data_s;
         end
      end
   end

   assign slot_end   = rise_q & (lrck_q != lrck_last);
   assign slot_short = bit_cnt < SHORT_LIM;

   // drop the incoming bit at its MSB-first position; bits past the word are ignored
   always_comb begin
      word_in = sh;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1 - i)) begin
            word_in[i] = sh[i] | data_q;
         end
      end
   end

   // per-slot bit counter and deserializer, restarted at every slot end
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) begin
         lrck_last <= 1'b0;
         bit_cnt   <= '0;
         sh        <= '0;
      end else if (rise_q) begin
         lrck_last <= lrck_q;
         if (slot_end) begin
            bit_cnt <= '0;
            sh      <= '0;
         end else begin
            sh <= word_in;
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // framing state register
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) state <= S_IDLE;
      else            state <= state_nx;
   end

   // framing next state: arm on first LRCK change, then pair left with right
   always_comb begin
      state_nx = state;
      if (slot_end) begin
         unique case (state)
            S_IDLE:   state_nx = S_WAIT_L;
            S_WAIT_L: if (lrck_q) state_nx = S_HAVE_L;
            S_HAVE_L: if (!lrck_q) state_nx = S_WAIT_L;
            default:  state_nx = S_IDLE;
         endcase
      end
   end

   // framing outputs: latch a finished left word or launch a full frame
   always_comb begin
      left_load = 1'b0;
      frame_go  = 1'b0;
      if (slot_end && state != S_IDLE) begin
         left_load = lrck_q;
         frame_go  = !lrck_q && state == S_HAVE_L;
      end
   end

   // hold completed words and their short-slot flags
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) begin
         left_hold  <= '0;
         right_hold <= '0;
         lerr       <= 1'b0;
         rerr       <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         frame_q <= frame_go;
         if (left_load) begin
            left_hold <= word_in;
            lerr      <= slot_short;
         end
         if (frame_go) begin
            right_hold <= word_in;
            rerr       <= slot_short;
         end
      end
   end

   // present a finished frame for one MCLK and keep the words afterwards
   always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
      if (!ARESETN_I) begin
         i2s.PCML_O     <= '0;
         i2s.PCMR_O     <= '0;
         i2s.VALID_O    <= 1'b0;
         i2s.SLOT_ERR_O <= 1'b0;
      end else begin
         i2s.VALID_O    <= frame_q;
         i2s.SLOT_ERR_O <= frame_q & (lerr | rerr);
         if (frame_q) begin
            i2s.PCML_O <= $signed(left_hold);
            i2s.PCMR_O <= $signed(right_hold);
         end
      end
   end

endmodule

// File: tb/tb_i2s_pcm_mclk.sv
// Randomized bench for the I2S receiver: drives slot streams into a
// 32-bit and a 24-bit instance and scores them against a slot-level model.
module tb_i2s_pcm_mclk;

   localparam int LAT = 4;

   typedef struct packed {
      logic [31:0] l;
      logic [31:0] r;
      logic        e;
   } frame_t;

   logic mclk = 1'b0;
   logic rst_n = 1'b0;
   logic bclk = 1'b0;
   logic lrck = 1'b0;
   logic data = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned mcyc    = 0;
   int unsigned t_rise  = 0;
   int unsigned last_v  = 0;
   int          half    = 4;
   bit          chk_per = 1'b0;

   int          s_lr[$];
   int          s_n[$];
   logic [63:0] s_w[$];
   frame_t      q32[$];
   frame_t      q24[$];
   frame_t      f32 = '0;
   frame_t      f24 = '0;

   i2s_pcm_mclk_if #(.DATA_WIDTH(32)) bus32 ();
   i2s_pcm_mclk_if #(.DATA_WIDTH(24)) bus24 ();

   assign bus32.BCLK_I = bclk;
   assign bus32.LRCK_I = lrck;
   assign bus32.DATA_I = data;
   assign bus24.BCLK_I = bclk;
   assign bus24.LRCK_I = lrck;
   assign bus24.DATA_I = data;

   i2s_pcm_mclk #(
      .DATA_WIDTH (32),
      .SYNC_STAGES(2),
      .CNT_WIDTH  (6)
   ) u32 (
      .MCLK_I   (mclk),
      .ARESETN_I(rst_n),
      .i2s      (bus32.slave)
   );

   i2s_pcm_mclk #(
      .DATA_WIDTH (24),
      .SYNC_STAGES(2),
      .CNT_WIDTH  (6)
   ) u24 (
      .MCLK_I   (mclk),
      .ARESETN_I(rst_n),
      .i2s      (bus24.slave)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) mcyc++;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // word seen by a dw-bit receiver for an n-bit slot carrying w
   function automatic logic [31:0] rx_word(logic [63:0] w, int n, int dw);
      logic [63:0] v;
      if (n >= dw) v = w >> (n - dw);
      else         v = w << (dw - n);
      return v[31:0];
   endfunction

   // expected frames for slots lo..hi-1 received after a reset
   function automatic void model(int lo, int hi);
      int     first = -1;
      int     prev  = 0;
      frame_t f;
      for (int i = lo; i < hi; i++) begin
         if (first < 0 && s_lr[i] != prev) first = i;
         prev = s_lr[i];
      end
      if (first < 0) return;
      for (int i = first; i + 2 < hi; i++) begin
         if (s_lr[i] == 0 && s_lr[i+1] == 1) begin
            f.l = rx_word(s_w[i], s_n[i], 32);
            f.r = rx_word(s_w[i+1], s_n[i+1], 32);
            f.e = (s_n[i] < 32) || (s_n[i+1] < 32);
            q32.push_back(f);
            f.l = rx_word(s_w[i], s_n[i], 24);
            f.r = rx_word(s_w[i+1], s_n[i+1], 24);
            f.e = (s_n[i] < 24) || (s_n[i+1] < 24);
            q24.push_back(f);
         end
      end
   endfunction

   // scoreboard for the 32-bit receiver
   always @(posedge mclk) begin
      #1;
      if (!rst_n) f32 = '0;
      if (bus32.VALID_O) begin
         if (q32.size() == 0) begin
            check("v32_extra", bus32.VALID_O, 1'b0);
         end else begin
            f32 = q32.pop_front();
            check("l32", bus32.PCML_O, f32.l);
            check("r32", bus32.PCMR_O, f32.r);
            check("e32", bus32.SLOT_ERR_O, f32.e);
            check("lat32", mcyc - t_rise, LAT);
            if (chk_per && last_v != 0) check("per32", mcyc - last_v, 512);
            last_v = mcyc;
         end
      end else begin
         check("hold_l32", bus32.PCML_O, f32.l);
         check("hold_r32", bus32.PCMR_O, f32.r);
         check("idle_e32", bus32.SLOT_ERR_O, 1'b0);
      end
   end

   // scoreboard for the 24-bit receiver
   always @(posedge mclk) begin
      #1;
      if (!rst_n) f24 = '0;
      if (bus24.VALID_O) begin
         if (q24.size() == 0) begin
            check("v24_extra", bus24.VALID_O, 1'b0);
         end else begin
            f24 = q24.pop_front();
            check("l24", {8'b0, bus24.PCML_O}, f24.l);
            check("r24", {8'b0, bus24.PCMR_O}, f24.r);
            check("e24", bus24.SLOT_ERR_O, f24.e);
            check("lat24", mcyc - t_rise, LAT);
         end
      end else begin
         check("hold_l24", {8'b0, bus24.PCML_O}, f24.l);
         check("hold_r24", {8'b0, bus24.PCMR_O}, f24.r);
         check("idle_e24", bus24.SLOT_ERR_O, 1'b0);
      end
   end

   task automatic add_slot(int lr, int n, logic [63:0] w);
      s_lr.push_back(lr);
      s_n.push_back(n);
      s_w.push_back(w & ((64'd1 << n) - 64'd1));
   endtask

   task automatic gen_rand(int cnt, int lr0, int nmin, int nmax);
      for (int k = 0; k < cnt; k++) begin
         add_slot(lr0 ^ (k & 1), $urandom_range(nmax, nmin),
                  {$urandom, $urandom});
      end
   endtask

   task automatic bit_period(logic lr, logic d, bit mark);
      @(negedge mclk);
      bclk = 1'b0;
      lrck = lr;
      data = d;
      repeat (half - 1) @(negedge mclk);
      @(negedge mclk);
      bclk = 1'b1;
      if (mark) t_rise = mcyc + 1;
      repeat (half - 1) @(negedge mclk);
   endtask

   task automatic start(int idle_lr);
      @(negedge mclk);
      rst_n = 1'b0;
      bclk  = 1'b0;
      lrck  = idle_lr[0];
      data  = 1'b0;
      s_lr.delete();
      s_n.delete();
      s_w.delete();
      q32.delete();
      q24.delete();
      last_v = 0;
      repeat (3) @(negedge mclk);
      rst_n = 1'b1;
      repeat (2) @(negedge mclk);
   endtask

   task automatic mid_reset();
      check("pre_rst_q32", q32.size(), 0);
      check("pre_rst_q24", q24.size(), 0);
      @(negedge mclk);
      rst_n = 1'b0;
      #1;
      check("rst_l32", bus32.PCML_O, 0);
      check("rst_r32", bus32.PCMR_O, 0);
      check("rst_l24", {8'b0, bus24.PCML_O}, 0);
      check("rst_v32", bus32.VALID_O, 1'b0);
      repeat (3) @(negedge mclk);
      rst_n = 1'b1;
   endtask

   // play the slot list as an I2S stream, optionally resetting mid-slot
   task automatic send(int rst_slot, int rst_bit);
      logic        prev_lsb = 1'b0;
      logic [63:0] w;
      int          hi = s_lr.size();
      if (rst_slot < 0) model(0, hi);
      else              model(0, rst_slot + 1);
      for (int i = 0; i < hi; i++) begin
         w = s_w[i];
         for (int j = 0; j < s_n[i]; j++) begin
            if (i == rst_slot && j == rst_bit) begin
               mid_reset();
               model(rst_slot, hi);
            end
            bit_period(s_lr[i][0], (j == 0) ? prev_lsb : w[s_n[i]-j], j == 0);
         end
         prev_lsb = w[0];
      end
      repeat (20) @(negedge mclk);
      check("drain32", q32.size(), 0);
      check("drain24", q24.size(), 0);
   endtask

   initial begin
      repeat (4) @(negedge mclk);
      check("init_l32", bus32.PCML_O, 0);
      check("init_v32", bus32.VALID_O, 1'b0);
      check("init_e24", bus24.SLOT_ERR_O, 1'b0);

      // loopback pattern, 32-bit slots, BCLK = MCLK/8
      start(0);
      half = 4;
      chk_per = 1'b1;
      for (int k = 0; k < 4; k++) begin
         add_slot(0, 32, 64'h12345678);
         add_slot(1, 32, 64'hEDCBA987);
      end
      add_slot(0, 32, 64'h0);
      send(-1, 0);
      chk_per = 1'b0;

      // 24-bit content in 32-bit slots with ones padding
      start(0);
      for (int k = 0; k < 3; k++) begin
         add_slot(0, 32, 64'h7FFFFFFF);
         add_slot(1, 32, 64'h800000FF);
      end
      add_slot(0, 32, 64'h0);
      send(-1, 0);

      // short 16-bit slots
      start(0);
      for (int k = 0; k < 3; k++) begin
         add_slot(0, 16, 64'hABCD);
         add_slot(1, 16, 64'h1234);
      end
      add_slot(0, 16, 64'h0);
      send(-1, 0);

      // stream starting in the middle of a right slot
      start(1);
      add_slot(1, 13, {$urandom, $urandom});
      gen_rand(7, 0, 32, 32);
      send(-1, 0);

      // reset in the middle of a left slot
      start(0);
      gen_rand(11, 0, 32, 32);
      send(4, 10);

      // random slot lengths, words and BCLK ratios
      for (int r = 0; r < 4; r++) begin
         start(0);
         half = $urandom_range(5, 2);
         gen_rand(9, $urandom_range(1, 0), 8, 48);
         send(-1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
